if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline; sole producer of the instruction word whose opcode field feeds the ID-stage control decoder.
- Owns the PC, issues requests to a variable-latency instruction memory, and holds the IF/ID pipeline register.
- Honours stall from the hazard unit and redirect/flush from branch resolution.
- Supplies a NOP-safe opcode whenever no valid instruction is present.

Parameters:
- ADDR_W, 32, PC and memory address width.
- INST_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC after reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset (synchronous, active-high)
- start_i  in  1  level; fetching runs while high
- stall_i  in  1  hazard unit: hold IF/ID and PC
- flush_i  in  1  squash IF/ID contents (branch taken in ID)
- redirect_i  in  1  load PC from redirect_pc_i
- redirect_pc_i  in  ADDR_W  branch/jump target
- imem_req_o  out  1  request valid
- imem_addr_o  out  ADDR_W  request address (= PC)
- imem_ack_i  in  1  memory accepted request this cycle
- imem_valid_i  in  1  read data valid
- imem_rdata_i  in  INST_W  read data
- ifid_valid_o  out  1  IF/ID holds a real instruction
- ifid_pc_o  out  ADDR_W  PC of IF/ID instruction
- ifid_inst_o  out  INST_W  IF/ID instruction (NOP_INST when invalid)
- opcode_o  out  7  ifid_inst_o[6:0], to control decoder

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is synchronous, active-high.
- Reset values: PC=RESET_PC, state=IDLE, imem_req_o=0, ifid_valid_o=0, ifid_pc_o=0, ifid_inst_o=NOP_INST, discard flag=0. Reset overrides every other input in the same cycle.
- States:
  - IDLE: no request. Go to REQ when start_i=1.
  - REQ: imem_req_o=1, imem_addr_o=PC. On imem_ack_i go to WAIT. If imem_ack_i and imem_valid_i arrive in the same cycle, treat as a zero-latency return and apply the WAIT response handling in that cycle.
  - WAIT: imem_req_o=0; wait for imem_valid_i.
  - HOLD: response captured into a skid register while stall_i=1. Leave when stall_i=0.
- Response handling (WAIT, imem_valid_i=1):
  - If the discard flag is set: drop the data, clear the flag, go to REQ.
  - Else if stall_i=0: load IF/ID with {valid=1, pc=PC, inst=imem_rdata_i}; PC<=PC+4; go to REQ, or IDLE if start_i=0.
  - Else: capture into the skid register and go to HOLD.
- HOLD to REQ: on the first cycle with stall_i=0, skid contents move into IF/ID and PC<=PC+4. Latency is exactly 1 cycle after the stall drops.
- Stall: with stall_i=1, IF/ID and PC are frozen and no new request is issued from REQ. An outstanding WAIT request still completes, into the skid register.
- Flush: flush_i=1 loads IF/ID with {valid=0, inst=NOP_INST} on the next edge. Flush beats stall. It also empties the skid register.
- Redirect:
  - redirect_i=1: PC<=redirect_pc_i.
  - In WAIT, also set the discard flag.
  - In HOLD, empty the skid register and go to REQ.
  - If a redirect and a valid response land on the same edge, the response is discarded.
  - redirect_pc_i[1:0] must be 0; bits [1:0] are forced to 0.
- PC arithmetic: modulo 2^ADDR_W; 32'hFFFF_FFFC+4 wraps to 0.
- start_i low: finish any outstanding request normally, then go to IDLE. Never abandon an acked request.
- Reset mid-WAIT: the late imem_valid_i after reset is ignored (state=IDLE, no discard flag needed).
- opcode_o: combinational slice of ifid_inst_o. An invalid slot yields 7'b0010011 (ALU-immediate, writes x0).

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_o[31:0] and perf_stall_o[31:0].
  - perf_fetch_o increments on each IF/ID load with valid=1.
  - perf_stall_o increments on each cycle with stall_i=1 and start_i=1.
  - Both counters reset to 0, saturate at 32'hFFFF_FFFF, and are cleared by rst_i only.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package rv_pkg: opcode constants (OP_RTYPE 0110011, OP_ITYPE 0010011, OP_LOAD 0000011, OP_STORE 0100011, OP_BRANCH 1100011), NOP_INST, the if_state_t enum {IDLE, REQ, WAIT, HOLD}, and the ifid_t struct {valid, pc, inst}.
- One sub-module: if_skid_buf (single-entry skid register with load/drain/clear).

Test Plan:
- Reset, start_i=1, memory ack plus valid with 2-cycle latency returning 0x00500093 → IF/ID pc=0, inst=0x00500093, opcode_o=0010011; next imem_addr_o=4.
- stall_i=1 for 3 cycles while WAIT returns 0x00208133 → IF/ID unchanged for 3 cycles; IF/ID pc=4 loads 1 cycle after stall_i falls; PC=8.
- redirect_i=1, redirect_pc_i=0x100, while WAIT for PC=8 → returning data dropped; next request address 0x100; IF/ID never shows pc=8.
- flush_i and stall_i together → IF/ID valid=0, inst=0x00000013, opcode_o=0010011.
- PC preset via redirect to 0xFFFF_FFFC, one fetch completes → next imem_addr_o=0x0000_0000.
- rst_i asserted during WAIT, imem_valid_i arrives next cycle → all outputs at reset values; no IF/ID load.

Source files
------------

// File: rtl/rv_pkg.sv
// ============================================================================
// Module      : rv_pkg
// Description : Shared RISC-V pipeline types: opcodes, bubble instruction,
//               fetch-stage state encoding and IF/ID record.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } if_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } ifid_t;

endpackage

`default_nettype wire

// File: rtl/if_skid_buf.sv
// ============================================================================
// Module      : if_skid_buf
// Description : Single-entry skid register; clear beats load, load beats drain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_skid_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_drain,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module      : if_stage
// Description : RISC-V instruction-fetch stage: PC, variable-latency imem
//               handshake, IF/ID register. Optional counters: IF_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage import rv_pkg::*; #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INST_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_0000,
    parameter logic [INST_W-1:0]  NOP_INST = rv_pkg::NOP_INST
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic              imem_valid_i,
    input  logic [INST_W-1:0] imem_rdata_i,
    output logic              ifid_valid_o,
    output logic [ADDR_W-1:0] ifid_pc_o,
    output logic [INST_W-1:0] ifid_inst_o,
    output logic [6:0]        opcode_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_o,
    output logic [31:0]       perf_stall_o
`endif
);

    if_state_t         r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_discard;
    logic              r_ifid_valid;
    logic [ADDR_W-1:0] r_ifid_pc;
    logic [INST_W-1:0] r_ifid_inst;

    logic              w_req;
    logic              w_accept;
    logic              w_resp;
    logic              w_resp_use;
    logic              w_resp_load;
    logic              w_skid_load;
    logic              w_hold_release;
    logic              w_ifid_load;
    logic [INST_W-1:0] w_load_data;
    logic [ADDR_W-1:0] w_redirect_pc;
    logic [ADDR_W-1:0] w_pc_next;
    if_state_t         w_run_state;
    logic              w_skid_valid;
    logic [INST_W-1:0] w_skid_data;

    assign w_req    = (r_state == REQ) && start_i && !stall_i;
    assign w_accept = w_req && imem_ack_i;

    // A response in REQ only counts when it rides on an accepted request.
    assign w_resp      = ((r_state == WAIT) && imem_valid_i) || (w_accept && imem_valid_i);
    assign w_resp_use  = w_resp && !r_discard && !redirect_i && !flush_i;
    assign w_resp_load = w_resp_use && !stall_i;
    assign w_skid_load = w_resp_use && stall_i;

    assign w_hold_release = (r_state == HOLD) && w_skid_valid && !stall_i
                            && !flush_i && !redirect_i;
    assign w_ifid_load    = w_resp_load || w_hold_release;
    assign w_load_data    = (r_state == HOLD) ? w_skid_data : imem_rdata_i;

    assign w_redirect_pc = redirect_pc_i & ~ADDR_W'(3);
    assign w_pc_next     = r_pc + ADDR_W'(4);
    assign w_run_state   = start_i ? REQ : IDLE;

    if_skid_buf #(
        .DATA_W (INST_W)
    ) u_skid (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_load  (w_skid_load),
        .i_drain (w_hold_release),
        .i_clear (flush_i || redirect_i),
        .i_data  (imem_rdata_i),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_discard    <= 1'b0;
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= '0;
            r_ifid_inst  <= NOP_INST;
        end else begin
            if (flush_i) begin
                r_ifid_valid <= 1'b0;
                r_ifid_inst  <= NOP_INST;
            end else if (w_ifid_load) begin
                r_ifid_valid <= 1'b1;
                r_ifid_pc    <= r_pc;
                r_ifid_inst  <= w_load_data;
            end

            if (redirect_i) begin
                r_pc <= w_redirect_pc;
            end else if (w_ifid_load) begin
                r_pc <= w_pc_next;
            end

            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (!start_i) begin
                        r_state <= IDLE;
                    end else if (w_accept && !imem_valid_i) begin
                        // An acked request for the old PC must be dropped on return.
                        r_state   <= WAIT;
                        r_discard <= redirect_i;
                    end
                end
                WAIT: begin
                    if (imem_valid_i) begin
                        r_discard <= 1'b0;
                        r_state   <= w_skid_load ? HOLD : w_run_state;
                    end else if (redirect_i) begin
                        r_discard <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_i || flush_i || !stall_i) begin
                        r_state <= w_run_state;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign imem_req_o   = w_req;
    assign imem_addr_o  = r_pc;
    assign ifid_valid_o = r_ifid_valid;
    assign ifid_pc_o    = r_ifid_pc;
    assign ifid_inst_o  = r_ifid_inst;
    assign opcode_o     = r_ifid_inst[6:0];

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_ifid_load && (r_perf_fetch != 32'hFFFF_FFFF)) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (stall_i && start_i && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetch_o = r_perf_fetch;
    assign perf_stall_o = r_perf_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module      : tb_if_stage
// Description : Cycle-vector bench for if_stage; inputs applied per cycle,
//               imem request checked before the edge, IF/ID after it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

    typedef struct {
        logic        rst, start, stall, flush, redir;
        logic [31:0] rpc;
        logic        ack, valid;
        logic [31:0] rdata;
        logic        chk_pre;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic        chk_pc;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    logic        clk;
    logic        rst_i, start_i, stall_i, flush_i, redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i, imem_valid_i;
    logic [31:0] imem_rdata_i;
    logic        ifid_valid_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_inst_o;
    logic [6:0]  opcode_o;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_o;
    logic [31:0] perf_stall_o;
`endif

    int n_checks = 0;
    int n_err    = 0;

    if_stage dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_valid_i  (imem_valid_i),
        .imem_rdata_i  (imem_rdata_i),
        .ifid_valid_o  (ifid_valid_o),
        .ifid_pc_o     (ifid_pc_o),
        .ifid_inst_o   (ifid_inst_o),
`ifdef IF_PERF_CNT_EN
        .perf_fetch_o  (perf_fetch_o),
        .perf_stall_o  (perf_stall_o),
`endif
        .opcode_o      (opcode_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(
        input logic rst, input logic start, input logic stall, input logic flush,
        input logic redir, input logic [31:0] rpc, input logic ack, input logic valid,
        input logic [31:0] rdata, input logic cp, input logic er, input logic [31:0] ea,
        input logic ev, input logic cpc, input logic [31:0] epc, input logic [31:0] einst);
        vec_t v;
        v.rst = rst; v.start = start; v.stall = stall; v.flush = flush; v.redir = redir;
        v.rpc = rpc; v.ack = ack; v.valid = valid; v.rdata = rdata;
        v.chk_pre = cp; v.e_req = er; v.e_addr = ea;
        v.e_v = ev; v.chk_pc = cpc; v.e_pc = epc; v.e_inst = einst;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        logic [6:0] e_op;
        rst_i = v.rst; start_i = v.start; stall_i = v.stall; flush_i = v.flush;
        redirect_i = v.redir; redirect_pc_i = v.rpc;
        imem_ack_i = v.ack; imem_valid_i = v.valid; imem_rdata_i = v.rdata;
        #3;
        if (v.chk_pre) begin
            chk({tag, " req"},  {31'd0, imem_req_o}, {31'd0, v.e_req});
            chk({tag, " addr"}, imem_addr_o, v.e_addr);
        end
        @(posedge clk);
        #1;
        e_op = v.e_inst[6:0];
        chk({tag, " ifid_valid"}, {31'd0, ifid_valid_o}, {31'd0, v.e_v});
        if (v.chk_pc) chk({tag, " ifid_pc"}, ifid_pc_o, v.e_pc);
        chk({tag, " ifid_inst"}, ifid_inst_o, v.e_inst);
        chk({tag, " opcode"}, {25'd0, opcode_o}, {25'd0, e_op});
    endtask

    vec_t vecs[$];

    initial begin
        rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0;
        redirect_pc_i = '0; imem_ack_i = 1'b0; imem_valid_i = 1'b0; imem_rdata_i = '0;

        //             rst st sl fl rd rpc           ak vl rdata          cp rq addr          v  cp pc            inst
        vecs.push_back(mk(1,0,0,0,0, 32'h0,        0,0, 32'h0,        0,0, 32'h0,        0,1, 32'h0,        32'h13));
        vecs.push_back(mk(1,0,0,0,0, 32'h0,        0,0, 32'h0,        1,0, 32'h0,        0,1, 32'h0,        32'h13));
        vecs.push_back(mk(0,1,0,0,0, 32'h0,        0,0, 32'h0,        1,0, 32'h0,        0,1, 32'h0,        32'h13));
        vecs.push_back(mk(0,1,0,0,0, 32'h0,        1,0, 32'h0,        1,1, 32'h0,        0,1, 32'h0,        32'h13));
        vecs.push_back(mk(0,1,0,0,0, 32'h0,        0,0, 32'h0,        1,0, 32'h0,        0,1, 32'h0,        32'h13));
        vecs.push_back(mk(0,1,0,0,0, 32'h0,        0,1, 32'h00500093, 1,0, 32'h0,        1,1, 32'h0,        32'h00500093));
        vecs.push_back(mk(0,1,0,0,0, 32'h0,        1,0, 32'h0,        1,1, 32'h4,        1,1, 32'h0,        32'h00500093));
        // stall for three cycles while the response returns
        vecs.push_back(mk(0,1,1,0,0, 32'h0,        0,1, 32'h00208133, 1,0, 32'h4,        1,1, 32'h0,        32'h00500093));
        vecs.push_back(mk(0,1,1,0,0, 32'h0,        0,0, 32'h0,        1,0, 32'h4,        1,1, 32'h0,        32'h00500093));
        vecs.push_back(mk(0,1,1,0,0, 32'h0,        0,0, 32'h0,        1,0, 32'h4,        1,1, 32'h0,        32'h00500093));
        vecs.push_back(mk(0,1,0,0,0, 32'h0,        0,0, 32'h0,        1,0, 32'h4,        1,1, 32'h4,        32'h00208133));
        vecs.push_back(mk(0,1,0,0,0, 32'h0,        1,0, 32'h0,        1,1, 32'h8,        1,1, 32'h4,        32'h00208133));
        // redirect during WAIT: the returning word for pc=8 is dropped
        vecs.push_back(mk(0,1,0,0,1, 32'h100,      0,0, 32'h0,        1,0, 32'h8,        1,1, 32'h4,        32'h00208133));
        vecs.push_back(mk(0,1,0,0,0, 32'h0,        0,1, 32'h00800093, 1,0, 32'h100,      1,1, 32'h4,        32'h00208133));
        vecs.push_back(mk(0,1,0,0,0, 32'h0,        1,1, 32'h00100093, 1,1, 32'h100,      1,1, 32'h100,      32'h00100093));
        vecs.push_back(mk(0,1,1,1,0, 32'h0,        0,0, 32'h0,        1,0, 32'h104,      0,0, 32'h0,        32'h13));
        vecs.push_back(mk(0,1,0,0,1, 32'hFFFFFFFE, 0,0, 32'h0,        1,1, 32'h104,      0,0, 32'h0,        32'h13));
        vecs.push_back(mk(0,1,0,0,0, 32'h0,        1,0, 32'h0,        1,1, 32'hFFFFFFFC, 0,0, 32'h0,        32'h13));
        vecs.push_back(mk(0,1,0,0,0, 32'h0,        0,1, 32'h00000513, 1,0, 32'hFFFFFFFC, 1,1, 32'hFFFFFFFC, 32'h00000513));
        vecs.push_back(mk(0,1,0,0,0, 32'h0,        1,0, 32'h0,        1,1, 32'h0,        1,1, 32'hFFFFFFFC, 32'h00000513));
        // reset while WAIT; late valid afterwards must be ignored
        vecs.push_back(mk(1,1,0,0,0, 32'h0,        0,0, 32'h0,        1,0, 32'h0,        0,1, 32'h0,        32'h13));
        vecs.push_back(mk(0,1,0,0,0, 32'h0,        0,1, 32'hBAD00093, 1,0, 32'h0,        0,1, 32'h0,        32'h13));
        vecs.push_back(mk(0,1,0,0,0, 32'h0,        1,0, 32'h0,        1,1, 32'h0,        0,1, 32'h0,        32'h13));
        vecs.push_back(mk(0,0,0,0,0, 32'h0,        0,1, 32'h00C00093, 1,0, 32'h0,        1,1, 32'h0,        32'h00C00093));
        vecs.push_back(mk(0,0,0,0,0, 32'h0,        0,0, 32'h0,        1,0, 32'h4,        1,1, 32'h0,        32'h00C00093));

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // Redirect while a stalled response sits in the skid: it must never reach IF/ID.
        step(mk(0,1,0,0,0, 32'h0,   0,0, 32'h0,        1,0, 32'h4,   1,1, 32'h0,   32'h00C00093), "hold0");
        step(mk(0,1,0,0,0, 32'h0,   1,0, 32'h0,        1,1, 32'h4,   1,1, 32'h0,   32'h00C00093), "hold1");
        step(mk(0,1,1,0,0, 32'h0,   0,1, 32'h00400093, 1,0, 32'h4,   1,1, 32'h0,   32'h00C00093), "hold2");
        step(mk(0,1,1,0,1, 32'h200, 0,0, 32'h0,        1,0, 32'h4,   1,1, 32'h0,   32'h00C00093), "hold3");
        step(mk(0,1,0,0,0, 32'h0,   0,0, 32'h0,        1,1, 32'h200, 1,1, 32'h0,   32'h00C00093), "hold4");
        step(mk(0,1,0,0,0, 32'h0,   1,0, 32'h0,        1,1, 32'h200, 1,1, 32'h0,   32'h00C00093), "hold5");
        step(mk(0,1,0,0,0, 32'h0,   0,1, 32'h00700093, 1,0, 32'h200, 1,1, 32'h200, 32'h00700093), "hold6");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
